// File: rtl/seq_div8b_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div8b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int W = 8;
  localparam int CNT_W = 4;
  localparam logic [7:0] DZ_QUOT = 8'hFF;

endpackage

// File: rtl/seq_div8b_sub9b.sv
// Trial subtractor: difference plus borrow-out of two unsigned values.
module sub9b #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d,
  output logic         bout
);

  assign {bout, d} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_div8b.sv
// Unsigned restoring divider: one quotient bit per RUN cycle.
module seq_div8b #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  import seq_div8b_pkg::*;

  state_e state, state_nx;

  logic [W-1:0] dvd;
  logic [W-1:0] dvs;
  logic [W-1:0] prem;
  logic [W-1:0] qacc;
  logic [CNT_W-1:0] cnt;

  logic [W:0] trial;
  logic [W:0] diff;
  logic [W:0] rem_nx;
  logic       bout;
  logic       qbit;
  logic       accept;
  logic       last;
  logic       unused;

  assign trial = {prem, dvd[W-1]};

  sub9b #(.N(W+1)) u_sub (
    .a    (trial),
    .b    ({1'b0, dvs}),
    .d    (diff),
    .bout (bout)
  );

  // Restore on borrow; the kept remainder always fits in W bits.
  assign rem_nx = bout ? trial : diff;
  assign unused = rem_nx[W];
  assign qbit   = ~bout;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CNT_W'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_nx = (divisor == '0) ? DONE : RUN;
        else
          state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      qacc        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd  <= dividend;
      dvs  <= divisor;
      prem <= '0;
      qacc <= '0;
      cnt  <= '0;
      if (divisor == '0) begin
        quotient    <= W'(DZ_QUOT);
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      dvd  <= {dvd[W-2:0], 1'b0};
      prem <= rem_nx[W-1:0];
      qacc <= {qacc[W-2:0], qbit};
      if (last) begin
        quotient  <= {qacc[W-2:0], qbit};
        remainder <= rem_nx[W-1:0];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_div8b.md
SEQ_DIV8B -- requirements
Module: seq_div8b

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset: clk rises on every edge used; rst_n at 0 resets immediately, independent of clk.
REQ-002 SHALL expose ports, in this order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a division; sampled on the clk edge
- dividend  input  8  unsigned numerator; sampled only when start is accepted
- divisor  input  8  unsigned denominator; sampled only when start is accepted
- busy  output  1  high while iterating
- done  output  1  single-cycle pulse marking a valid result
- quotient  output  8  unsigned quotient
- remainder  output  8  unsigned remainder
- div_by_zero  output  1  the last accepted operation had divisor == 0
REQ-003 SHALL have one parameter, W, default 8, giving the operand width; all behaviour below is stated for W=8.

Function
REQ-004 SHALL implement the states IDLE, RUN and DONE, held in a state register.
REQ-005 start SHALL be accepted only when state is IDLE or DONE (busy=0); start while in RUN SHALL be ignored and SHALL NOT alter the operands.
REQ-006 On an accepted start with divisor != 0:
- latch dividend and divisor
- clear the partial remainder and iteration count to 0
- clear div_by_zero
- go to RUN
REQ-007 Each RUN cycle SHALL perform one restoring shift-subtract step:
- form trial = {partial_rem[7:0], next dividend MSB}, 9 bits
- diff = trial - {0, divisor}, 9 bits
- if no borrow: partial_rem = diff and the quotient bit is 1
- otherwise: partial_rem = trial and the quotient bit is 0
REQ-008 RUN SHALL last exactly 8 cycles. On the 8th RUN edge:
- quotient and remainder register the final values
- state goes to DONE
- done is high for exactly the following cycle
REQ-009 Latency SHALL be 8 clk edges from the accepting edge to the first cycle in which done is high.
REQ-010 On an accepted start with divisor == 0:
- skip RUN and go directly to DONE
- quotient = 8'hFF, remainder = dividend, div_by_zero = 1
- done is high in the cycle after the accepting edge
REQ-011 DONE SHALL return to IDLE on the next edge unless start is accepted on that same edge; in that case the new operation begins and done falls.
REQ-012 quotient, remainder and div_by_zero SHALL hold their values until the next result is registered; they SHALL NOT show intermediate values during RUN.
REQ-013 busy SHALL be 1 exactly when state is RUN.
REQ-014 The iteration counter SHALL be 4 bits and count 0..7; it SHALL NOT wrap while in RUN.
REQ-015 All arithmetic SHALL be unsigned; the 9-bit subtraction borrow is the sole compare decision.

Reset
REQ-016 While rst_n=0:
- state = IDLE
- busy = 0, done = 0, div_by_zero = 0
- quotient = 0, remainder = 0
- internal operands and counter = 0
REQ-017 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start accepted after release SHALL behave as from power-up.
REQ-018 rst_n deassertion SHALL take effect on the next clk edge; start sampled on that edge is honoured.

Structure
REQ-019 A shared package SHALL hold:
- the state enumeration (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
- the width constant W=8
- the counter width constant CNT_W=4
- the divide-by-zero quotient constant 8'hFF
REQ-020 The 9-bit trial subtraction SHALL be a separate combinational sub-module, sub9b:
- inputs a[8:0], b[8:0]
- outputs d[8:0], bout
- it is the subtract counterpart of the datapath's adder

Verification
REQ-021 The bench SHALL cover each of the following directed scenarios:
- dividend=100, divisor=7, start for 1 cycle -> busy for 8 cycles; done 8 edges later; quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 0/3 -> quotient=0, remainder=0.
- 77/0 -> done on the cycle after accept; quotient=8'hFF, remainder=77, div_by_zero=1; the next start of 10/3 clears div_by_zero and gives quotient=3, remainder=1.
- start of 200/10 accepted, then start of 9/3 pulsed during RUN -> ignored; the result is quotient=20, remainder=0 at the original latency.
- start held high continuously with 50/6 -> a new operation accepted on every DONE edge; done pulses every 9 cycles, each with quotient=8, remainder=2.
- rst_n pulled low at RUN cycle 4 of 123/5 -> all outputs 0 immediately; no done pulse; after release, 123/5 -> quotient=24, remainder=3.
